// File: rtl/modular_mul.sv
// Bit-serial interleaved modular multiplier: out_data = (opA * opB) mod opM.
// One multiplier bit per clock, MSB first. Each iteration doubles the
// accumulator, conditionally adds A, then applies two conditional
// subtractions of M so the accumulator stays fully reduced (R < M).
// Despite its name, rst_n is an asynchronous active-high reset.
module modular_mul #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Iteration counter counts WIDTH-1 down to 0.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Accumulator width: T = 2R + A < 3M < 2^(WIDTH+2) must not be truncated.
  localparam int EXT_W = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [EXT_W-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;

  // One interleaved iteration, fully combinational within the cycle.
  logic [EXT_W-1:0]   m_ext;
  logic [EXT_W-1:0]   addend;
  logic [EXT_W-1:0]   t_sum;
  logic [EXT_W-1:0]   t_red1;
  logic [EXT_W-1:0]   t_red2;

  assign m_ext  = {2'b00, m_q};
  assign addend = b_q[cnt_q] ? {2'b00, a_q} : '0;
  assign t_sum  = (r_q << 1) + addend;
  assign t_red1 = (t_sum  >= m_ext) ? (t_sum  - m_ext) : t_sum;
  assign t_red2 = (t_red1 >= m_ext) ? (t_red1 - m_ext) : t_red1;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    busy_d      = (state_q == CALC) || (state_q == DONE);
    out_valid_d = 1'b0;
    out_data_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = opA;
          b_d     = opB;
          m_d     = opM;
          r_d     = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        r_d = t_red2;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        out_data_d  = r_q[WIDTH-1:0];
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_modular_mul.sv
// Self-checking bench for modular_mul: directed vector table, random
// operands against a plain-arithmetic reference, and multi-cycle corner
// cases (busy rejection, back-to-back acceptance, mid-operation reset).
module tb_modular_mul;

  localparam int W = 256;

  localparam logic [W-1:0] P    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [W-1:0] HALF = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;
  localparam logic [W-1:0] ALL  = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] op_a, op_b, op_m;
  logic         busy, out_valid;
  logic [W-1:0] out_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  modular_mul #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .opA      (op_a),
    .opB      (op_b),
    .opM      (op_m),
    .busy     (busy),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width product reduced with the % operator.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] rem;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    rem  = prod % {{W{1'b0}}, m};
    return rem[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Present operands for one edge, then scramble them so later changes are visible.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    @(negedge clk);
    op_a     = a;
    op_b     = b;
    op_m     = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a     = rand_w();
    op_b     = rand_w();
    op_m     = rand_w();
  endtask

  // Count edges after acceptance until out_valid; k = -1 when the budget runs out.
  task automatic collect(input int k0, output int k, output logic [W-1:0] data,
                         output int busy_cnt, output logic zero_ok);
    logic seen;
    seen     = 1'b0;
    k        = k0;
    busy_cnt = 0;
    zero_ok  = 1'b1;
    data     = '0;
    while (!seen && k < W + 20) begin
      @(posedge clk);
      k++;
      #1;
      if (busy) busy_cnt++;
      if (out_valid) begin
        seen = 1'b1;
        data = out_data;
      end else if (out_data != '0) begin
        zero_ok = 1'b0;
      end
    end
    if (!seen) k = -1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m,
                        input logic [W-1:0] exp, input string name, input logic chk_data);
    int           k, bc;
    logic [W-1:0] d;
    logic         zok;
    accept(a, b, m);
    collect(0, k, d, bc, zok);
    check({name, " latency"}, k, W + 1);
    if (chk_data) check({name, " data"}, d, exp);
    check({name, " busy cycles"}, bc, W + 1);
    check({name, " data zero while invalid"}, zok, 1'b1);
    @(posedge clk);
    #1;
    check({name, " valid/busy after"}, {busy, out_valid}, 2'b00);
    check({name, " data after"}, out_data, '0);
  endtask

  initial begin
    int           k, bc, pulses;
    logic [W-1:0] d, a, b, m;
    logic         zok, idle_ok;

    vecs[0]  = '{64'd3, 64'd5, 64'd7, 64'd1, "3*5 mod 7"};
    vecs[1]  = '{64'd2, HALF, P, 64'd1, "2*inv2 mod p"};
    vecs[2]  = '{P - 1, P - 1, P, 64'd1, "(p-1)^2 mod p"};
    vecs[3]  = '{64'd0, P - 1, P, 64'd0, "0*(p-1)"};
    vecs[4]  = '{64'd1, 64'h1234, P, 64'h1234, "1*0x1234"};
    vecs[5]  = '{64'd2, 64'd2, 64'd7, 64'd4, "2*2 mod 7"};
    vecs[6]  = '{64'd6, 64'd6, 64'd7, 64'd1, "6*6 mod 7"};
    vecs[7]  = '{64'd1, 64'd1, 64'd2, 64'd1, "1*1 mod 2"};
    vecs[8]  = '{64'd0, 64'd1, 64'd2, 64'd0, "0*1 mod 2"};
    vecs[9]  = '{ALL - 1, ALL - 1, ALL, 64'd1, "max modulus square"};
    vecs[10] = '{ALL - 1, 64'd1, ALL, ALL - 1, "max modulus times 1"};
    vecs[11] = '{P - 1, 64'd2, P, P - 2, "(p-1)*2 mod p"};

    rst_n    = 1'b1;
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    op_m     = '0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    check("in reset valid/busy", {busy, out_valid}, 2'b00);
    @(negedge clk);
    rst_n   = 1'b0;
    idle_ok = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (busy || out_valid || out_data != '0) idle_ok = 1'b0;
    end
    check("idle outputs quiet", idle_ok, 1'b1);

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      check({vecs[i].name, " model"}, ref_mul(vecs[i].a, vecs[i].b, vecs[i].m), vecs[i].exp);
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].exp, vecs[i].name, 1'b1);
    end

    // Random in-contract operands against the reference.
    for (int i = 0; i < 14; i++) begin
      m = (rand_w() >> $urandom_range(0, W - 3)) | 2;
      a = rand_w() % m;
      b = (i % 4 == 0) ? m - 1 : rand_w() % m;
      run_op(a, b, m, ref_mul(a, b, m), $sformatf("rand%0d", i), 1'b1);
    end

    // Out-of-contract operands: only termination with one pulse matters.
    run_op(ALL, ALL, 64'd1, '0, "out of contract", 1'b0);

    // Busy rejection, then acceptance in the cycle out_valid falls.
    accept(64'd3, 64'd5, 64'd7);
    repeat (99) @(posedge clk);
    @(negedge clk);
    op_a     = 64'd2;
    op_b     = 64'd2;
    op_m     = 64'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    collect(100, k, d, bc, zok);
    check("busy reject latency", k, W + 1);
    check("busy reject data", d, 64'd1);
    accept(64'd2, 64'd2, 64'd7);
    collect(0, k, d, bc, zok);
    check("back-to-back latency", k, W + 1);
    check("back-to-back data", d, 64'd4);
    pulses = 0;
    repeat (W + 20) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("no queued result", pulses, 0);

    // Reset in the middle of an operation.
    accept(64'd3, 64'd5, 64'd7);
    repeat (49) @(posedge clk);
    #1;
    check("busy before abort", busy, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("abort async valid/busy", {busy, out_valid}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b0;
    pulses = 0;
    repeat (W + 20) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    check("aborted op no result", pulses, 0);
    run_op(64'd3, 64'd5, 64'd7, 64'd1, "after abort", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
